// File: rtl/comm_slave.sv
`timescale 1ns/1ps
// comm_slave: copter-side end of the wireless command link.
//   Receives 3-byte 8N1 UART frames (cmd, data[15:8], data[7:0]) and presents
//   them as a parallel command with a cmd_rdy handshake; transmits one
//   response byte on request. RX and TX paths run independently (full duplex).
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   RX / TX         serial in (asynchronous, idle high) / serial out (idle high)
//   cmd, data       last complete frame
//   cmd_rdy         frame available; cleared by clr_cmd_rdy pulse
//   send_resp, resp start transmitting resp (ignored while tx_busy)
//   tx_busy         transmitter active
//   resp_sent       one-cycle pulse at end of the response stop bit
//   overrun         one-cycle pulse when a frame overwrites an uncleared one
module comm_slave #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        overrun
);
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // ---------------- RX synchroniser (preset to line-idle level) ----------
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- RX bit FSM + frame assembler -------------------------
    uart_state_t rx_state_q, rx_state_d;
    logic [11:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  shadow0_q, shadow0_d, shadow1_q, shadow1_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d, overrun_q, overrun_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        start_det, byte_valid, frame_err;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        start_det  = 1'b0;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_det  = 1'b1;
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    // Mid-start-bit resample rejects short glitches.
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 12'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 12'd1;
                end
            end
            default: begin // S_STOP
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    byte_valid = rx_sync_q;
                    frame_err  = !rx_sync_q;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 12'd1;
                end
            end
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        shadow0_d  = shadow0_q;
        shadow1_d  = shadow1_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        cmd_rdy_d  = cmd_rdy_q & ~clr_cmd_rdy;
        overrun_d  = 1'b0;
        idle_cnt_d = idle_cnt_q;

        // Inter-byte timeout only counts while a frame is partially assembled
        // and the line is idle between bytes.
        if (start_det || idx_q == 2'd0) begin
            idle_cnt_d = '0;
        end else if (rx_state_q == S_IDLE) begin
            if (idle_cnt_q == TO_LAST) begin
                idle_cnt_d = '0;
                idx_d      = 2'd0;
            end else begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
        end

        if (frame_err) begin
            idx_d = 2'd0;
        end else if (byte_valid) begin
            case (idx_q)
                2'd0: begin
                    shadow0_d = rx_shift_q;
                    idx_d     = 2'd1;
                end
                2'd1: begin
                    shadow1_d = rx_shift_q;
                    idx_d     = 2'd2;
                end
                2'd2: begin
                    cmd_d     = shadow0_q;
                    data_d    = {shadow1_q, rx_shift_q};
                    cmd_rdy_d = 1'b1;        // set beats a coincident clear
                    overrun_d = cmd_rdy_q;
                    idx_d     = 2'd0;
                end
                default: idx_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            idx_q      <= '0;
            shadow0_q  <= '0;
            shadow1_q  <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            cmd_rdy_q  <= 1'b0;
            overrun_q  <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            idx_q      <= idx_d;
            shadow0_q  <= shadow0_d;
            shadow1_q  <= shadow1_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cmd_rdy_q  <= cmd_rdy_d;
            overrun_q  <= overrun_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // ---------------- TX FSM ------------------------------------------------
    uart_state_t tx_state_q, tx_state_d;
    logic [11:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_busy_q, tx_busy_d, resp_sent_q, resp_sent_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        resp_sent_d = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_shift_d = resp;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 12'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        // TX is registered, so present the next bit now.
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 12'd1;
                end
            end
            default: begin // S_STOP
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d    = '0;
                    tx_busy_d   = 1'b0;
                    resp_sent_d = 1'b1;
                    tx_state_d  = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 12'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign data      = data_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign overrun   = overrun_q;
    assign tx_busy   = tx_busy_q;
    assign resp_sent = resp_sent_q;
endmodule

// File: tb/tb_comm_slave.sv
`timescale 1ns/1ps
module tb_comm_slave;
    localparam int BAUD = 16;
    localparam int TMO  = 100;
    localparam int BYTE_CYC = 10 * BAUD;
    // Cycle index within send_byte whose value the DUT sees on the stop-sample
    // edge: 3 edges to sync + detect, BAUD/2 to mid-start, 9 bit periods.
    localparam int CLR_C = 3 + BAUD / 2 + 9 * BAUD - 1;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp;
    logic        tx_busy, resp_sent, overrun;
    logic [7:0]  cmd, resp;
    logic [15:0] data;

    comm_slave #(.BAUD_DIV(BAUD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp), .tx_busy(tx_busy), .resp_sent(resp_sent), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic        ovr;
    } frame_t;

    frame_t     fq[$];
    logic [7:0] rq[$];
    int total = 0;
    int bad   = 0;
    int resp_sent_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One UART byte, then a one-bit idle gap. clr_cmd_rdy is driven high at
    // cycle clr_at of the byte (-1: never).
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int clr_at);
        int s;
        @(posedge clk); #1;
        for (int c = 0; c < BYTE_CYC; c++) begin
            s = c / BAUD;
            if (s == 0)      RX = 1'b0;
            else if (s == 9) RX = stop_ok;
            else             RX = b[s-1];
            clr_cmd_rdy = (c == clr_at);
            @(posedge clk); #1;
        end
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        repeat (BAUD) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1, -1);
        send_byte(b1, 1'b1, -1);
        send_byte(b2, 1'b1, -1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_send(input logic [7:0] r);
        @(posedge clk); #1 resp = r; send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;
    endtask

    // ---------------- frame monitor ----------------
    logic rdy_prev = 1'b0;
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst) begin
                rdy_prev = 1'b0;
            end else begin
                if ((cmd_rdy && !rdy_prev) || overrun) begin
                    if (fq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_unexpected: got cmd=0x%0h data=0x%0h ovr=%0b, required none",
                                 cmd, data, overrun);
                    end else begin
                        f = fq.pop_front();
                        check("frame_cmd", 32'(cmd), 32'(f.c));
                        check("frame_data", 32'(data), 32'(f.d));
                        check("frame_overrun", 32'(overrun), 32'(f.ovr));
                        check("frame_rdy", 32'(cmd_rdy), 32'd1);
                    end
                end
                rdy_prev = cmd_rdy;
                if (resp_sent) resp_sent_cnt++;
            end
        end
    end

    // ---------------- TX monitor ----------------
    logic       busy_prev = 1'b0;
    logic       tx_s [0:BYTE_CYC-1];
    logic       aborted;
    int         wave_err, busy_err;
    logic [7:0] exp_b, dec_b;
    initial begin
        logic lvl;
        forever begin
            @(negedge clk);
            if (!rst && tx_busy && !busy_prev) begin
                aborted  = 1'b0;
                busy_err = 0;
                for (int k = 0; k < BYTE_CYC; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    tx_s[k] = TX;
                    if (!tx_busy) busy_err++;
                end
                if (!aborted) begin
                    @(negedge clk);
                    check("resp_sent_end", 32'(resp_sent), 32'd1);
                    check("tx_busy_end", 32'(tx_busy), 32'd0);
                    check("tx_busy_held", 32'(busy_err), 32'd0);
                    if (rq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected: got a transmitted byte, required none");
                    end else begin
                        exp_b = rq.pop_front();
                        wave_err = 0;
                        for (int k = 0; k < BYTE_CYC; k++) begin
                            if (k < BAUD)             lvl = 1'b0;
                            else if (k >= 9 * BAUD)   lvl = 1'b1;
                            else                      lvl = exp_b[k / BAUD - 1];
                            if (tx_s[k] !== lvl) wave_err++;
                        end
                        for (int j = 0; j < 8; j++) dec_b[j] = tx_s[(j + 1) * BAUD + BAUD / 2];
                        check("tx_byte", 32'(dec_b), 32'(exp_b));
                        check("tx_wave_errs", 32'(wave_err), 32'd0);
                    end
                end
            end
            busy_prev = rst ? 1'b0 : tx_busy;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_TX"}, 32'(TX), 32'd1);
        check({tag, "_cmd"}, 32'(cmd), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd0);
        check({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
        check({tag, "_resp_sent"}, 32'(resp_sent), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Basic frame, then clear.
        fq.push_back('{8'h02, 16'h00FA, 1'b0});
        send_frame(8'h02, 8'h00, 8'hFA);
        check("basic_rdy", 32'(cmd_rdy), 32'd1);
        pulse_clr();
        check("clr_rdy", 32'(cmd_rdy), 32'd0);
        check("clr_cmd_hold", 32'(cmd), 32'h02);
        check("clr_data_hold", 32'(data), 32'h00FA);

        // Response byte; a second request mid-byte must be ignored.
        rq.push_back(8'hA5);
        pulse_send(8'hA5);
        repeat (80) @(posedge clk);
        pulse_send(8'h00);
        repeat (100) @(posedge clk);
        #1 check("resp_idle_TX", 32'(TX), 32'd1);

        // Framing error discards the byte and restarts the assembler.
        fq.push_back('{8'h05, 16'h0123, 1'b0});
        send_byte(8'h06, 1'b0, -1);
        send_frame(8'h05, 8'h01, 8'h23);
        pulse_clr();

        // Inter-byte timeout drops the lone 0x03.
        fq.push_back('{8'h04, 16'h0010, 1'b0});
        send_byte(8'h03, 1'b1, -1);
        repeat (200) @(posedge clk);
        send_frame(8'h04, 8'h00, 8'h10);
        pulse_clr();

        // Overrun, then completion coinciding with a clear.
        fq.push_back('{8'h01, 16'h0000, 1'b0});
        send_frame(8'h01, 8'h00, 8'h00);
        fq.push_back('{8'h07, 16'h1234, 1'b1});
        send_frame(8'h07, 8'h12, 8'h34);
        #1 check("ovr_rdy_held", 32'(cmd_rdy), 32'd1);
        pulse_clr();
        check("ovr_clr", 32'(cmd_rdy), 32'd0);
        fq.push_back('{8'h09, 16'hABCD, 1'b0});
        send_byte(8'h09, 1'b1, -1);
        send_byte(8'hAB, 1'b1, -1);
        send_byte(8'hCD, 1'b1, CLR_C);
        #1 check("set_wins_rdy", 32'(cmd_rdy), 32'd1);
        pulse_clr();

        // Reset during RX bit 4 and mid-TX.
        pulse_send(8'h3C);
        fork
            send_byte(8'h55, 1'b1, -1);
            begin
                repeat (86) @(posedge clk);
                #3 rst = 1'b1;
                #1 check_reset_outputs("rstmid");
            end
        join
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_reset_outputs("postrst");
        fq.push_back('{8'h08, 16'h0000, 1'b0});
        send_frame(8'h08, 8'h00, 8'h00);
        #1 check("postrst_rdy", 32'(cmd_rdy), 32'd1);

        repeat (20) @(posedge clk);
        check("frames_left", 32'(fq.size()), 32'd0);
        check("resp_left", 32'(rq.size()), 32'd0);
        check("resp_sent_pulses", 32'(resp_sent_cnt), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
